// File: rtl/duty_ramp.sv
// Slew-limited duty source feeding an 8-bit PWM generator: accepts a target via
// valid/ready and walks duty toward it by at most STEP per PWM period.
module duty_ramp #(
    parameter int STEP     = 1,
    parameter int PERIOD_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tgt_duty,
    input  logic       tgt_vld,
    output logic       tgt_rdy,
    output logic [7:0] duty,
    output logic       period_tick,
    output logic       settled
);

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DN
    } state_t;

    localparam logic [9:0] STEP_D = 10'(STEP);
    localparam logic [7:0] STEP_B = 8'(STEP);

    logic [PERIOD_W-1:0] prd_cnt_reg, prd_cnt_next;
    logic [7:0]          act_tgt_reg, act_tgt_next;
    logic [7:0]          pend_reg, pend_next;
    logic                pend_vld_reg, pend_vld_next;
    logic [7:0]          duty_reg, duty_next;
    state_t              state_reg, state_next;

    logic                tick;
    logic                capture;
    logic [7:0]          nt;
    logic signed [9:0]   diff;
    logic [9:0]          abs_diff;
    logic [7:0]          stepped;

    assign tick        = (prd_cnt_reg == '1);
    assign capture     = tgt_vld && !pend_vld_reg;
    assign tgt_rdy     = !pend_vld_reg;
    assign period_tick = tick;
    assign duty        = duty_reg;
    assign settled     = (state_reg == IDLE) && !pend_vld_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            prd_cnt_reg  <= '0;
            act_tgt_reg  <= 8'h00;
            pend_reg     <= 8'h00;
            pend_vld_reg <= 1'b0;
            duty_reg     <= 8'h00;
            state_reg    <= IDLE;
        end else begin
            prd_cnt_reg  <= prd_cnt_next;
            act_tgt_reg  <= act_tgt_next;
            pend_reg     <= pend_next;
            pend_vld_reg <= pend_vld_next;
            duty_reg     <= duty_next;
            state_reg    <= state_next;
        end
    end

    always_comb begin
        prd_cnt_next  = prd_cnt_reg + 1'b1;
        act_tgt_next  = act_tgt_reg;
        pend_next     = pend_reg;
        pend_vld_next = pend_vld_reg;
        duty_next     = duty_reg;
        state_next    = state_reg;

        // A pending target is consumed at the tick; a same-edge capture only
        // happens when the slot is empty, so it simply refills it.
        nt       = pend_vld_reg ? pend_reg : act_tgt_reg;
        diff     = signed'({2'b00, nt}) - signed'({2'b00, duty_reg});
        abs_diff = diff[9] ? 10'(-diff) : 10'(diff);

        if (abs_diff <= STEP_D) begin
            stepped = nt;
        end else if (!diff[9]) begin
            stepped = duty_reg + STEP_B;
        end else begin
            stepped = duty_reg - STEP_B;
        end

        if (capture) begin
            pend_next     = tgt_duty;
            pend_vld_next = 1'b1;
        end else if (tick) begin
            pend_vld_next = 1'b0;
        end

        if (tick) begin
            act_tgt_next = nt;
            duty_next    = stepped;
            if (stepped == nt) begin
                state_next = IDLE;
            end else if (stepped < nt) begin
                state_next = RAMP_UP;
            end else begin
                state_next = RAMP_DN;
            end
        end
    end

endmodule

// File: tb/tb_duty_ramp.sv
// Directed bench for duty_ramp: one instance with STEP=1 and one with STEP=16,
// exercised through a vector table plus hand-written multi-cycle sequences.
module tb_duty_ramp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, vld_a, rdy_a, tick_a, set_a;
    logic [7:0] tgt_a, duty_a;
    logic       rst_b, vld_b, rdy_b, tick_b, set_b;
    logic [7:0] tgt_b, duty_b;

    duty_ramp #(.STEP(1), .PERIOD_W(8)) u_s1 (
        .clk(clk), .rst(rst_a), .tgt_duty(tgt_a), .tgt_vld(vld_a),
        .tgt_rdy(rdy_a), .duty(duty_a), .period_tick(tick_a), .settled(set_a)
    );

    duty_ramp #(.STEP(16), .PERIOD_W(8)) u_s16 (
        .clk(clk), .rst(rst_b), .tgt_duty(tgt_b), .tgt_vld(vld_b),
        .tgt_rdy(rdy_b), .duty(duty_b), .period_tick(tick_b), .settled(set_b)
    );

    typedef struct {
        int       sel;
        bit       send;
        bit [7:0] tgt;
        bit [7:0] exp_duty;
        bit       exp_settled;
    } vec_t;

    vec_t vecs[13];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic g_tick(input int sel);
        return sel != 0 ? tick_b : tick_a;
    endfunction

    function automatic logic [7:0] g_duty(input int sel);
        return sel != 0 ? duty_b : duty_a;
    endfunction

    function automatic logic g_rdy(input int sel);
        return sel != 0 ? rdy_b : rdy_a;
    endfunction

    function automatic logic g_set(input int sel);
        return sel != 0 ? set_b : set_a;
    endfunction

    // Leaves the caller at the negedge just after the next tick edge.
    task automatic wait_tick(input int sel);
        int n = 0;
        while (!g_tick(sel) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("tick_seen", int'(g_tick(sel)), 1);
        @(negedge clk);
    endtask

    task automatic send(input int sel, input logic [7:0] val);
        if (sel != 0) begin tgt_b = val; vld_b = 1'b1; end
        else          begin tgt_a = val; vld_a = 1'b1; end
        @(negedge clk);
        vld_a = 1'b0;
        vld_b = 1'b0;
        check("send_rdy_low", int'(g_rdy(sel)), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;

        vecs[0]  = '{0, 1'b0, 8'h00, 8'h01, 1'b0};
        vecs[1]  = '{0, 1'b0, 8'h00, 8'h02, 1'b0};
        vecs[2]  = '{0, 1'b0, 8'h00, 8'h03, 1'b0};
        vecs[3]  = '{0, 1'b0, 8'h00, 8'h04, 1'b1};
        vecs[4]  = '{1, 1'b1, 8'h28, 8'h10, 1'b0};
        vecs[5]  = '{1, 1'b0, 8'h00, 8'h20, 1'b0};
        vecs[6]  = '{1, 1'b0, 8'h00, 8'h28, 1'b1};
        vecs[7]  = '{1, 1'b0, 8'h00, 8'h28, 1'b1};
        vecs[8]  = '{1, 1'b1, 8'h00, 8'h18, 1'b0};
        vecs[9]  = '{1, 1'b0, 8'h00, 8'h08, 1'b0};
        vecs[10] = '{1, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[11] = '{1, 1'b1, 8'hF0, 8'h10, 1'b0};
        vecs[12] = '{1, 1'b0, 8'h00, 8'h20, 1'b0};

        rst_a = 1'b1; vld_a = 1'b0; tgt_a = 8'h00;
        rst_b = 1'b1; vld_b = 1'b0; tgt_b = 8'h00;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int s = 0; s < 2; s++) begin
            check($sformatf("rst%0d_duty", s), int'(g_duty(s)), 0);
            check($sformatf("rst%0d_rdy", s), int'(g_rdy(s)), 1);
            check($sformatf("rst%0d_settled", s), int'(g_set(s)), 1);
            check($sformatf("rst%0d_tick", s), int'(g_tick(s)), 0);
        end

        cnt = 0;
        while (!tick_a && cnt < 300) begin @(negedge clk); cnt++; end
        check("first_tick_delay", cnt, 255);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!tick_a && cnt < 300);
        check("tick_period", cnt, 256);
        $display("tick timing: first=255 period=%0d", cnt);

        // Up ramp on STEP=1: capture at cycle 10 after a fresh reset
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        repeat (10) @(negedge clk);
        tgt_a = 8'h04; vld_a = 1'b1;
        @(negedge clk);
        vld_a = 1'b0;
        check("cap10_rdy", int'(rdy_a), 0);
        check("cap10_duty", int'(duty_a), 0);
        check("cap10_settled", int'(set_a), 0);
        $display("capture 0x04 at cycle 10");

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].send) send(vecs[i].sel, vecs[i].tgt);
            wait_tick(vecs[i].sel);
            check($sformatf("vec%0d_duty", i), int'(g_duty(vecs[i].sel)), int'(vecs[i].exp_duty));
            check($sformatf("vec%0d_settled", i), int'(g_set(vecs[i].sel)), int'(vecs[i].exp_settled));
            check($sformatf("vec%0d_rdy", i), int'(g_rdy(vecs[i].sel)), 1);
            $display("vec %0d: sel=%0d duty=0x%02h settled=%0b", i, vecs[i].sel,
                     g_duty(vecs[i].sel), g_set(vecs[i].sel));
        end

        // Retarget with back-pressure on STEP=16 (duty 0x20 ramping to 0xF0)
        tgt_b = 8'h05; vld_b = 1'b1;
        @(negedge clk);
        tgt_b = 8'h80;
        check("bp_rdy_low", int'(rdy_b), 0);
        repeat (20) @(negedge clk);
        check("bp_rdy_held", int'(rdy_b), 0);
        wait_tick(1);
        check("retgt_duty", int'(duty_b), 8'h10);
        check("retgt_rdy", int'(rdy_b), 1);
        check("retgt_settled", int'(set_b), 0);
        @(negedge clk);
        vld_b = 1'b0;
        check("bp_cap_rdy", int'(rdy_b), 0);
        wait_tick(1);
        check("bp_next_duty", int'(duty_b), 8'h20);
        $display("retarget: reversed to 0x10, then 0x80 applied -> 0x%02h", duty_b);

        // Capture in the tick cycle on STEP=1 (duty 0x04 settled)
        cnt = 0;
        while (!tick_a && cnt < 300) begin @(negedge clk); cnt++; end
        check("tcap_tick", int'(tick_a), 1);
        check("tcap_rdy", int'(rdy_a), 1);
        tgt_a = 8'h03; vld_a = 1'b1;
        @(negedge clk);
        vld_a = 1'b0;
        check("tcap_duty_hold", int'(duty_a), 8'h04);
        check("tcap_pending", int'(rdy_a), 0);
        wait_tick(0);
        check("tcap_duty_step", int'(duty_a), 8'h03);
        check("tcap_settled", int'(set_a), 1);
        $display("tick-cycle capture: duty=0x%02h", duty_a);

        // Reset mid-ramp on STEP=1
        send(0, 8'h60);
        for (int k = 0; k < 61; k++) wait_tick(0);
        check("mid_duty", int'(duty_a), 8'h40);
        repeat (5) @(negedge clk);
        tgt_a = 8'h10; vld_a = 1'b1;
        @(negedge clk);
        vld_a = 1'b0;
        check("mid_pending", int'(rdy_a), 0);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check("mrst_duty", int'(duty_a), 0);
        check("mrst_rdy", int'(rdy_a), 1);
        check("mrst_settled", int'(set_a), 1);
        check("mrst_tick", int'(tick_a), 0);
        cnt = 0;
        while (!tick_a && cnt < 300) begin @(negedge clk); cnt++; end
        check("mrst_tick_delay", cnt, 255);
        @(negedge clk);
        check("mrst_after_duty", int'(duty_a), 0);
        check("mrst_after_settled", int'(set_a), 1);
        $display("mid-ramp reset: duty=0x%02h tick after %0d clocks", duty_a, cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
